// File: rtl/chunked_serial_adder_if.sv
// Handshake bundle for chunked_serial_adder.
// Covers the operand side (in_*) and the result side (out_*).
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair CHUNK bits per clock,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chunked_serial_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NSLOT  = 1 << CW;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("chunked_serial_adder: CHUNK must divide WIDTH with 1 <= CHUNK <= WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  state_t               state_n;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic                 carry;
  logic [CW-1:0]        cnt;
  logic                 cout_r;
  logic                 ovf_r;
  logic [CHUNK-1:0]     sum_ch [NSLOT];
  logic [CHUNK-1:0]     a_ch   [NSLOT];
  logic [CHUNK-1:0]     b_ch   [NSLOT];
  logic [WIDTH-1:0]     sum_flat;
  logic [CHUNK+1:0]     cres;

  // Returns {signed-overflow, carry-out, CHUNK-bit sum}. The carry into the chunk MSB
  // is recovered from the MSB sum bit, so CHUNK=1 needs no special case.
  function automatic logic [CHUNK+1:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
    logic [CHUNK:0] t;
    logic           cmsb;
    t    = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    cmsb = t[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
    return {cmsb ^ t[CHUNK], t};
  endfunction

  // Slot view of the operand and result registers; spare slots exist only so that
  // the counter width exactly matches the array index width.
  for (genvar j = 0; j < NSLOT; j++) begin : g_slot
    if (j < NCHUNK) begin : g_used
      assign a_ch[j] = a_r[j*CHUNK +: CHUNK];
      assign b_ch[j] = b_r[j*CHUNK +: CHUNK];
      assign sum_flat[j*CHUNK +: CHUNK] = sum_ch[j];
    end else begin : g_spare
      assign a_ch[j] = '0;
      assign b_ch[j] = '0;
    end
  end

  assign cres     = chunk_add(a_ch[cnt], b_ch[cnt], carry);
  assign bus.sum  = sum_flat;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture in IDLE, one chunk per cycle in RUN; everything holds in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      for (int j = 0; j < NSLOT; j++) sum_ch[j] <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      a_r   <= bus.a;
      b_r   <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub | bus.cin;
      cnt   <= '0;
      for (int j = 0; j < NSLOT; j++) sum_ch[j] <= '0;
    end else if (state == RUN) begin
      sum_ch[cnt] <= cres[CHUNK-1:0];
      carry       <= cres[CHUNK];
      if (cnt == LAST) begin
        cout_r <= cres[CHUNK];
        ovf_r  <= cres[CHUNK+1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (CHUNK = 4, 16, 1) on a 16-bit word,
// directed vectors, back-pressure and reset-abort sequences, and random operations.
module tb_chunked_serial_adder;

  localparam int NU = 3;

  logic        clk;
  logic        rst_n;
  logic        iv  [NU];
  logic        cv  [NU];
  logic        sv  [NU];
  logic        orv [NU];
  logic [15:0] av  [NU];
  logic [15:0] bv  [NU];
  logic        ir  [NU];
  logic        ovl [NU];
  logic        cov [NU];
  logic        ofv [NU];
  logic        bsy [NU];
  logic [15:0] sm  [NU];

  int lat_exp [NU] = '{4, 1, 16};
  int nerr = 0;
  int nchk = 0;

  for (genvar g = 0; g < NU; g++) begin : g_u
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    chunked_serial_adder_if #(.WIDTH(16)) bus ();
    assign bus.in_valid  = iv[g];
    assign bus.a         = av[g];
    assign bus.b         = bv[g];
    assign bus.cin       = cv[g];
    assign bus.sub       = sv[g];
    assign bus.out_ready = orv[g];
    assign ir[g]  = bus.in_ready;
    assign ovl[g] = bus.out_valid;
    assign sm[g]  = bus.sum;
    assign cov[g] = bus.cout;
    assign ofv[g] = bus.ovf;
    assign bsy[g] = bus.busy;
    chunked_serial_adder #(.WIDTH(16), .CHUNK(CH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/carry and signed for overflow.
  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic sb);
    int ux, uy, sx, sy, ur, sr;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      ur = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end else begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      co = (ur > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, ur[15:0]};
  endfunction

  task automatic wait_out(input int u, output int lat);
    lat = 0;
    while (!ovl[u] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input int u, input logic [15:0] ta, input logic [15:0] tb2,
                        input logic tc, input logic ts, input logic [15:0] es,
                        input logic ec, input logic eo, input int hold);
    int n;
    int lat;
    logic [15:0] s0;
    logic c0, o0;
    @(negedge clk);
    av[u] = ta; bv[u] = tb2; cv[u] = tc; sv[u] = ts; iv[u] = 1'b1; orv[u] = 1'b0;
    n = 0;
    while (!ir[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready before accept", ir[u], 1'b1);
    @(posedge clk); #1;
    iv[u] = 1'b0;
    av[u] = 16'($urandom); bv[u] = 16'($urandom);
    cv[u] = 1'($urandom);  sv[u] = 1'($urandom);
    if (hold == 0) orv[u] = 1'b1;
    wait_out(u, lat);
    check("latency", lat, lat_exp[u]);
    check("sum", sm[u], es);
    check("cout", cov[u], ec);
    check("ovf", ofv[u], eo);
    s0 = sm[u]; c0 = cov[u]; o0 = ofv[u];
    repeat (hold) begin
      @(posedge clk); #1;
      check("held result", {ovl[u], ir[u], cov[u], ofv[u], sm[u]}, {1'b1, 1'b0, c0, o0, s0});
    end
    orv[u] = 1'b1;
    @(posedge clk); #1;
    orv[u] = 1'b0;
    check("return to idle", {ovl[u], ir[u], bsy[u]}, 3'b010);
  endtask

  initial begin
    int lat;
    int seen;
    logic [17:0] r;
    logic [15:0] ra, rb;
    logic rc, rs;

    for (int u = 0; u < NU; u++) begin
      iv[u] = 1'b0; cv[u] = 1'b0; sv[u] = 1'b0; orv[u] = 1'b0; av[u] = '0; bv[u] = '0;
    end

    tbl[0] = '{16'h0001, 16'h0006, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[1] = '{16'h000F, 16'h0001, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h0003, 16'h0007, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[9] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs u0", {ovl[0], ir[0], bsy[0], cov[0], ofv[0], sm[0]},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    check("reset in_ready u1", {ir[1], ovl[1]}, 2'b10);
    check("reset in_ready u2", {ir[2], ovl[2]}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;

    for (int u = 0; u < NU; u++)
      for (int i = 0; i < 10; i++)
        run_op(u, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].s, tbl[i].c, tbl[i].o, i % 3);

    // Back-pressure: result held for 5 cycles while a new request waits.
    @(negedge clk);
    av[0] = 16'h1234; bv[0] = 16'h1111; cv[0] = 1'b0; sv[0] = 1'b0; iv[0] = 1'b1; orv[0] = 1'b0;
    @(posedge clk); #1;
    av[0] = 16'h0001; bv[0] = 16'h0001;
    wait_out(0, lat);
    check("bp latency", lat, 4);
    check("bp sum", sm[0], 16'h2345);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp hold", {ovl[0], ir[0], cov[0], ofv[0], sm[0]}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h2345});
    end
    orv[0] = 1'b1;
    @(posedge clk); #1;
    orv[0] = 1'b0;
    check("bp release", {ovl[0], ir[0], bsy[0]}, 3'b010);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("bp second accept", {ir[0], bsy[0]}, 2'b01);
    wait_out(0, lat);
    check("bp second latency", lat, 4);
    check("bp second sum", sm[0], 16'h0002);
    orv[0] = 1'b1;
    @(posedge clk); #1;
    orv[0] = 1'b0;
    check("bp second release", {ovl[0], ir[0]}, 2'b01);

    // Reset asserted in the second RUN cycle aborts the operation.
    @(negedge clk);
    av[0] = 16'h0003; bv[0] = 16'h0004; cv[0] = 1'b0; sv[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    check("abort busy before reset", bsy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort outputs", {ovl[0], ir[0], bsy[0], cov[0], ofv[0], sm[0]},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ovl[0] || !ir[0]) seen++;
    end
    check("no result after abort", seen, 0);
    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);

    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < ((u == 0) ? 60 : 200); i++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom);  rs = 1'($urandom);
        if (i % 8 == 0) rb = ra;
        r = ref_model(ra, rb, rc, rs);
        run_op(u, ra, rb, rc, rs, r[15:0], r[16], r[17], int'($urandom_range(0, 2)));
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor that generalises the fixed 4-bit ripple adder. It processes a WIDTH-bit operand pair CHUNK bits per clock and carries between chunks in a register, trading latency for a short carry chain. Operands are accepted and results returned over valid/ready handshakes, so the block drops into datapaths that have back-pressure. Add/subtract mode, external carry-in, carry-out and signed overflow are supported.

Parameters:
WIDTH, 16, operand and result width in bits; must be ≥1.
CHUNK, 4, bits summed per clock; 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0, else elaboration error.
(derived) NCHUNK = WIDTH/CHUNK, the number of compute cycles.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands on a/b/cin/sub are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A, unsigned or two's complement.
b  input  WIDTH  operand B.
cin  input  1  carry-in; used only when sub=0.
sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1, cin ignored.
out_valid  output  1  result outputs valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry out of MSB; in sub mode 1 means no borrow (A ≥ B unsigned).
ovf  output  1  signed overflow, equal to carry into MSB XOR carry out of MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, chunk counter=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T, latch A and B' (B' = sub ? ~b : b), set carry = sub ? 1 : cin, counter=0, clear sum, then go to RUN.
- RUN:
  - in_ready=0; a/b/cin/sub changes are ignored.
  - Each cycle: {c, s} = A[k*CHUNK +: CHUNK] + B'[k*CHUNK +: CHUNK] + carry, where k=counter.
  - Write s into sum[k*CHUNK +: CHUNK], set carry=c, counter++.
  - On the last chunk (k=NCHUNK-1): cout=c, ovf=(carry into bit WIDTH-1) ^ c, then go to DONE.
- Latency: operands accepted at edge T; out_valid is high after edge T+NCHUNK. With NCHUNK=1 the result is valid one cycle after acceptance.
- DONE:
  - out_valid=1; sum/cout/ovf are held stable until out_valid&&out_ready.
  - On that handshake edge go to IDLE and drop out_valid.
  - out_ready held low keeps DONE indefinitely with no change to outputs.
- No overlap: in_ready is 1 only in IDLE. Back-to-back throughput is one result per NCHUNK+2 cycles. in_valid asserted in RUN or DONE is not accepted; the source holds it until in_ready.
- sum contents during RUN are partial and undefined to consumers; only the out_valid window is qualified.
- out_ready in IDLE or RUN has no effect.
- Reset mid-RUN or mid-DONE aborts the operation. All outputs return to reset values immediately, and no out_valid is produced for the aborted operation.
- Wrap-around: the result is truncated to WIDTH bits; the carry is reported only on cout.
- The counter is wide enough for NCHUNK-1 ($clog2, minimum 1 bit) and never exceeds NCHUNK-1.

Test Plan:
(WIDTH=16, CHUNK=4 unless stated)
1. a=0x0001, b=0x0006, sub=0, cin=0 → after 4 cycles out_valid=1, sum=0x0007, cout=0, ovf=0; with out_ready=1 the next cycle is IDLE with in_ready=1.
2. a=0x000F, b=0x0001, cin=1 → sum=0x0011 (carry crosses the chunk boundary); a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
3. a=0x7FFF, b=0x0001 add → sum=0x8000, ovf=1, cout=0; sub a=0x0003, b=0x0007 → sum=0xFFFC, cout=0, ovf=0; sub a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1, cout=1.
4. Back-pressure: out_ready=0 for 5 cycles after out_valid → sum/cout/ovf/out_valid stable and in_ready=0 throughout; a new in_valid is not taken until out_ready=1 and the return to IDLE.
5. Assert rst_n=0 in the 2nd RUN cycle → outputs zero immediately; after release, in_ready=1 and no out_valid appears; the next operation computes correctly.
6. Re-elaborate with CHUNK=16 and with CHUNK=1; run 200 random a/b/sub/cin cases each → results match the reference a±b; latency is 1 and 16 cycles respectively.
